// File: rtl/sgbm_rst_seq.sv
// sgbm_rst_seq: staged reset release, clkin/DIV clock-enable strobe and a one-frame-at-a-time
// start/done scheduler for the SGBM core. Define SGBM_WDOG_EN to build the per-frame watchdog.
module sgbm_rst_seq #(
  parameter int NSTAGE      = 4,
  parameter int HOLD_CYC    = 200,
  parameter int STAGGER_CYC = 16,
  parameter int DIV         = 4,
  parameter int WDOG_LIM    = 1024
) (
  input  logic              clkin,
  input  logic              rst0,
  input  logic              soft_rst,
  output logic              clk_en,
  output logic [NSTAGE-1:0] stage_rstn,
  output logic              ready,
  input  logic              frame_start,
  output logic              frame_busy,
  input  logic              core_done,
  output logic              frame_done,
  output logic              err_timeout
);

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_REL  = 2'd1;
  localparam logic [1:0] S_IDLE = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  // seq_cnt serves both HOLD (up to HOLD_CYC-1) and REL (up to the last stage's release point)
  localparam int REL_LAST = (NSTAGE > 1) ? (NSTAGE - 1) * STAGGER_CYC : 0;
  localparam int SEQ_MAX  = (HOLD_CYC - 1 > REL_LAST) ? HOLD_CYC - 1 : REL_LAST;
  localparam int SEQ_W    = (SEQ_MAX > 0) ? $clog2(SEQ_MAX + 1) : 1;
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [SEQ_W-1:0]  seq_cnt;
  logic [SEQ_W-1:0]  seq_nxt;
  logic [SEQ_W-1:0]  seq_inc;
  logic [NSTAGE-1:0] rstn_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              wd_expire;
  logic [DIV_W-1:0]  div_cnt;
  logic              div_wrap;

  // Free-running divider; soft_rst deliberately leaves it alone so downstream strobes stay periodic
  assign div_wrap = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clkin or posedge rst0) begin
    if (rst0) begin
      div_cnt <= '0;
      clk_en  <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      clk_en  <= div_wrap;
    end
  end

  assign seq_inc = (seq_cnt == SEQ_W'(SEQ_MAX)) ? seq_cnt : seq_cnt + 1'b1;

`ifdef SGBM_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIM + 1);

  logic [WD_W-1:0] wd_cnt;

  // Expiry is the edge that would count the WDOG_LIM-th strobe seen in RUN
  assign wd_expire = (state == S_RUN) && clk_en && (wd_cnt == WD_W'(WDOG_LIM - 1));

  always_ff @(posedge clkin or posedge rst0) begin
    if (rst0) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (soft_rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (state == S_RUN && !core_done) begin
      if (wd_expire) begin
        wd_cnt      <= '0;
        err_timeout <= 1'b1;
      end else if (clk_en && wd_cnt != WD_W'(WDOG_LIM)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  // Without the watchdog RUN never expires; WDOG_LIM stays referenced so both builds share one parameter set
  assign wd_expire   = 1'b0 & (WDOG_LIM != 0);
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    seq_nxt   = seq_cnt;
    rstn_nxt  = stage_rstn;
    busy_nxt  = frame_busy;
    done_nxt  = 1'b0;
    case (state)
      S_HOLD: begin
        if (seq_cnt == SEQ_W'(HOLD_CYC - 1)) begin
          state_nxt   = S_REL;
          seq_nxt     = '0;
          rstn_nxt[0] = 1'b1;
        end else begin
          seq_nxt = seq_inc;
        end
      end
      S_REL: begin
        seq_nxt = seq_inc;
        for (int k = 1; k < NSTAGE; k++) begin
          if (int'(seq_cnt) == k * STAGGER_CYC - 1) rstn_nxt[k] = 1'b1;
        end
        if (stage_rstn[NSTAGE-1]) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (frame_start) begin
          state_nxt = S_RUN;
          busy_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        // core_done is checked first so a same-edge expiry still completes the frame cleanly
        if (core_done) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (wd_expire) begin
          state_nxt = S_HOLD;
          seq_nxt   = '0;
          rstn_nxt  = '0;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = S_HOLD;
    endcase
    if (soft_rst) begin
      state_nxt = S_HOLD;
      seq_nxt   = '0;
      rstn_nxt  = '0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clkin or posedge rst0) begin
    if (rst0) begin
      state      <= S_HOLD;
      seq_cnt    <= '0;
      stage_rstn <= '0;
      ready      <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      seq_cnt    <= seq_nxt;
      stage_rstn <= rstn_nxt;
      ready      <= (state_nxt == S_IDLE);
      frame_busy <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sgbm_rst_seq.sv
// Bench for sgbm_rst_seq: directed phases with randomized frame traffic, every cycle compared
// against a timeline model (edges since release, frame in flight, strobes seen in RUN).
module tb_sgbm_rst_seq;

  localparam int P_N = 4;
  localparam int P_H = 200;
  localparam int P_S = 16;
  localparam int P_D = 4;
`ifdef SGBM_WDOG_EN
  localparam int P_WDL = 8;
  localparam bit WD_ON = 1'b1;
`else
  localparam int P_WDL = 1024;
  localparam bit WD_ON = 1'b0;
`endif
  localparam int READY_AT = P_H + (P_N - 1) * P_S + 1;

  logic           clkin = 1'b0;
  logic           rst0 = 1'b1;
  logic           soft_rst = 1'b0;
  logic           frame_start = 1'b0;
  logic           core_done = 1'b0;
  logic           clk_en;
  logic [P_N-1:0] stage_rstn;
  logic           ready;
  logic           frame_busy;
  logic           frame_done;
  logic           err_timeout;

  int nvec = 0;
  int nmis = 0;
  int busy_n;
  int done_n;

  // reference model state
  int edge_cnt;
  int seq_t;
  int wd;
  bit m_busy;
  bit m_done;
  bit m_err;
  bit m_clk_en;

  sgbm_rst_seq #(
    .NSTAGE(P_N), .HOLD_CYC(P_H), .STAGGER_CYC(P_S), .DIV(P_D), .WDOG_LIM(P_WDL)
  ) dut (
    .clkin(clkin), .rst0(rst0), .soft_rst(soft_rst), .clk_en(clk_en),
    .stage_rstn(stage_rstn), .ready(ready), .frame_start(frame_start),
    .frame_busy(frame_busy), .core_done(core_done), .frame_done(frame_done),
    .err_timeout(err_timeout)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    edge_cnt = 0; seq_t = 0; wd = 0;
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_clk_en = 1'b0;
  endtask

  function automatic bit m_ready();
    return (seq_t >= READY_AT) && !m_busy;
  endfunction

  function automatic logic [P_N-1:0] exp_rstn(input int t);
    logic [P_N-1:0] r;
    for (int k = 0; k < P_N; k++) r[k] = (t >= P_H + k * P_S);
    return r;
  endfunction

  task automatic model_edge(input logic fs, input logic cd, input logic sr);
    bit strobe;
    strobe   = m_clk_en;
    edge_cnt = edge_cnt + 1;
    m_clk_en = (edge_cnt % P_D == 0);
    m_done   = 1'b0;
    if (sr) begin
      seq_t = 0; wd = 0; m_busy = 1'b0; m_err = 1'b0;
    end else if (m_busy) begin
      if (cd) begin
        m_busy = 1'b0; m_done = 1'b1; seq_t = seq_t + 1;
      end else begin
        if (strobe) wd = wd + 1;
        if (WD_ON && wd == P_WDL) begin
          m_err = 1'b1; m_busy = 1'b0; seq_t = 0; wd = 0;
        end else begin
          seq_t = seq_t + 1;
        end
      end
    end else begin
      if (m_ready() && fs) begin
        m_busy = 1'b1; wd = 0;
      end
      seq_t = seq_t + 1;
    end
  endtask

  task automatic check_all();
    chk("clk_en", 32'(clk_en), 32'(m_clk_en));
    chk("stage_rstn", 32'(stage_rstn), 32'(exp_rstn(seq_t)));
    chk("ready", 32'(ready), 32'(m_ready()));
    chk("frame_busy", 32'(frame_busy), 32'(m_busy));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
  endtask

  task automatic cyc();
    @(posedge clkin);
    model_edge(frame_start, core_done, soft_rst);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 400; i++) begin
      if (m_ready()) break;
      cyc();
    end
  endtask

  initial begin
    model_reset();
    repeat (3) begin
      @(posedge clkin); #1;
      check_all();
    end
    @(negedge clkin);
    rst0 = 1'b0;

    // power-up with ignored frame_start/core_done noise
    for (int i = 0; i < 260; i++) begin
      frame_start = (i < 240) && ($urandom_range(0, 3) == 0);
      core_done   = ($urandom_range(0, 3) == 0);
      cyc();
      if (i == 199) chk("pwr_e200_rstn", 32'(stage_rstn), 32'h1);
      if (i == 247) chk("pwr_e248_rstn", 32'(stage_rstn), 32'hF);
      if (i == 247) chk("pwr_e248_ready", 32'(ready), 32'h0);
      if (i == 248) chk("pwr_e249_ready", 32'(ready), 32'h1);
    end
    frame_start = 1'b0;
    core_done   = 1'b0;

    // 37-cycle frame with an ignored second start
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    busy_n = int'(frame_busy);
    done_n = int'(frame_done);
    for (int i = 1; i < 37; i++) begin
      frame_start = (i == 10);
      cyc();
      busy_n += int'(frame_busy);
      done_n += int'(frame_done);
    end
    frame_start = 1'b0;
    core_done = 1'b1; cyc(); core_done = 1'b0;
    done_n += int'(frame_done);
    repeat (3) begin
      cyc();
      busy_n += int'(frame_busy);
      done_n += int'(frame_done);
    end
`ifndef SGBM_WDOG_EN
    chk("frame_busy_len", 32'(busy_n), 32'd37);
    chk("frame_done_cnt", 32'(done_n), 32'd1);
`endif

    // randomized frames with stray core_done in IDLE and stray frame_start in RUN
    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(1, 8)) begin
        core_done = ($urandom_range(0, 2) == 0);
        cyc();
      end
      core_done = 1'b0;
      frame_start = 1'b1; cyc(); frame_start = 1'b0;
      repeat ($urandom_range(1, 40)) begin
        frame_start = ($urandom_range(0, 4) == 0);
        cyc();
      end
      frame_start = 1'b0;
      core_done = 1'b1; cyc(); core_done = 1'b0;
    end

    // soft_rst in RUN: immediate drop, full replay, no frame_done
    wait_ready();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    run(5);
    soft_rst = 1'b1; cyc(); soft_rst = 1'b0;
    chk("srst_rstn", 32'(stage_rstn), 32'h0);
    chk("srst_busy", 32'(frame_busy), 32'h0);
    done_n = 0;
    for (int i = 0; i < 199; i++) begin
      cyc();
      done_n += int'(frame_done);
    end
    chk("srst_hold_rstn", 32'(stage_rstn), 32'h0);
    cyc();
    chk("srst_rel0_rstn", 32'(stage_rstn), 32'h1);
    repeat (60) begin
      cyc();
      done_n += int'(frame_done);
    end
    chk("srst_no_done", 32'(done_n), 32'd0);

    // frame without core_done: waits forever, or times out with the watchdog
    wait_ready();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    run(50);
    chk("stall_busy", 32'(frame_busy), WD_ON ? 32'h0 : 32'h1);
    chk("stall_err", 32'(err_timeout), 32'(WD_ON));
    core_done = 1'b1; cyc(); core_done = 1'b0;
    run(260);
    chk("err_sticky", 32'(err_timeout), 32'(WD_ON));
    soft_rst = 1'b1; cyc(); soft_rst = 1'b0;
    chk("err_clear", 32'(err_timeout), 32'h0);

    // core_done on the same edge the watchdog would expire
    wait_ready();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!m_busy) break;
      core_done = WD_ON && (wd == P_WDL - 1) && m_clk_en;
      cyc();
    end
    core_done = 1'b0;
    if (m_busy) begin
      core_done = 1'b1; cyc(); core_done = 1'b0;
    end
    cyc();
    chk("sim_ready", 32'(ready), 32'h1);
    chk("sim_err", 32'(err_timeout), 32'h0);

    // rst0 mid-REL, then complete replay
    soft_rst = 1'b1; cyc(); soft_rst = 1'b0;
    run(220);
    chk("rel220_rstn", 32'(stage_rstn), 32'h3);
    #2 rst0 = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("arst_ready", 32'(ready), 32'h0);
    chk("arst_rstn", 32'(stage_rstn), 32'h0);
    #2 rst0 = 1'b0;
    run(260);
    chk("replay_ready", 32'(ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
